// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking gaps and frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     staged_q, staged_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]        bcd_q, bcd_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_start;

  function automatic logic [3:0] digit_at(input logic [DW-1:0] s, input logic [IDX_W-1:0] i);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (IDX_W'(k) == i) r = s[4*k +: 4];
    return r;
  endfunction

`ifdef SEG_LZ_SUPPRESS_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic lz_blank(input logic [DW-1:0] s, input logic [IDX_W-1:0] i);
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (IDX_W'(k) >= i && s[4*k +: 4] != 4'h0) nz = 1'b1;
    return (i != '0) && !nz;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      staged_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= '0;
      bcd_q        <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      staged_q     <= staged_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      bcd_q        <= bcd_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    staged_d    = staged_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    frame_start = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = BLANK;
          idx_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    // Frame-boundary swap first, so a coincident load refills staging and keeps pending set.
    if (frame_start && pending_q) begin
      shadow_d  = staged_q;
      pending_d = 1'b0;
    end
    if (load) begin
      staged_d  = digits_in;
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from next-cycle state so the registered copies line up with state_q.
  always_comb begin
    an_d         = '0;
    bcd_d        = 4'hF;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        an_d[k] = (IDX_W'(k) == idx_d);
      bcd_d        = digit_at(shadow_d, idx_d);
      frame_done_d = (idx_d == IDX_LAST) && (cnt_d == SHOW_LAST);
`ifdef SEG_LZ_SUPPRESS_EN
      if (lz_blank(shadow_d, idx_d)) bcd_d = 4'hF;
`endif
    end
  end

  assign an         = an_q;
  assign bcd_out    = bcd_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (40-cycle frames).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .bcd_out   (bcd_out),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_bcd(input logic [15:0] v, input int d);
    logic [3:0] r;
    r = v[4*d +: 4];
`ifdef SEG_LZ_SUPPRESS_EN
    if (d != 0 && (v >> (4*d)) == 16'h0) r = 4'hF;
`endif
    return r;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_an"}, 32'(an), 32'h0);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'hF);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Entered one cycle after the edge that moved into BLANK with digit 0.
  task automatic frame_chk(input logic [15:0] v, input int ld1_at, input logic [15:0] ld1_v,
                           input int ld2_at, input logic [15:0] ld2_v, input int stop_at);
    for (int c = 0; c < 40; c++) begin
      int d;
      int k;
      d = c / 10;
      k = c % 10;
      if (k < 2) begin
        chk($sformatf("blank_an_d%0d", d), 32'(an), 32'h0);
        chk($sformatf("blank_bcd_d%0d", d), 32'(bcd_out), 32'hF);
      end else begin
        chk($sformatf("show_an_d%0d", d), 32'(an), 32'(1 << d));
        chk($sformatf("show_bcd_d%0d", d), 32'(bcd_out), 32'(exp_bcd(v, d)));
      end
      chk($sformatf("frame_done_c%0d", c), 32'(frame_done), 32'(c == 39));
      if (c == stop_at) return;
      load      = (c == ld1_at) || (c == ld2_at);
      digits_in = (c == ld2_at) ? ld2_v : ld1_v;
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    idle_chk("reset");
    rst = 1'b0;
    step();
    idle_chk("idle_after_reset");

    digits_in = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    idle_chk("idle_loaded");
    enable = 1'b1;
    step();

    // 5678 lands mid-frame, AAAA collides with the boundary swap of 5678.
    frame_chk(16'h1234, 14, 16'h5678, 39, 16'hAAAA, -1);
    frame_chk(16'h5678, -1, 16'h0, -1, 16'h0, -1);
    frame_chk(16'hAAAA, -1, 16'h0, -1, 16'h0, -1);

    // Drop enable in the blanking gap ahead of digit 3.
    frame_chk(16'hAAAA, -1, 16'h0, -1, 16'h0, 30);
    enable = 1'b0;
    step();
    idle_chk("en_drop");
    step();
    idle_chk("en_drop_hold");
    enable = 1'b1;
    step();
    frame_chk(16'hAAAA, -1, 16'h0, -1, 16'h0, 24);

    // Asynchronous reset in the middle of digit 2.
    #2 rst = 1'b1;
    #1 idle_chk("async_rst");
    step();
    step();
    rst = 1'b0;
    #1 idle_chk("post_rst_idle");
    step();
    frame_chk(16'h0000, 5, 16'h0070, -1, 16'h0, -1);
    frame_chk(16'h0070, 5, 16'h0000, -1, 16'h0, -1);
    frame_chk(16'h0000, -1, 16'h0, -1, 16'h0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
